// File: rtl/yuv_pkg.sv
// Shared encodings for the YUV420 frame packer: plane codes, FSM states, default geometry.
package yuv_pkg;
  localparam int DEF_WIDTH  = 1280;
  localparam int DEF_HEIGHT = 720;

  localparam logic [1:0] PLANE_Y    = 2'd0;
  localparam logic [1:0] PLANE_U    = 2'd1;
  localparam logic [1:0] PLANE_V    = 2'd2;
  localparam logic [1:0] PLANE_NONE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLANE_Y = 3'd1,
    ST_PLANE_U = 3'd2,
    ST_PLANE_V = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic logic [1:0] plane_of(input state_t s);
    case (s)
      ST_PLANE_Y: plane_of = PLANE_Y;
      ST_PLANE_U: plane_of = PLANE_U;
      ST_PLANE_V: plane_of = PLANE_V;
      default:    plane_of = PLANE_NONE;
    endcase
  endfunction

  function automatic logic in_plane(input state_t s);
    in_plane = (s == ST_PLANE_Y) || (s == ST_PLANE_U) || (s == ST_PLANE_V);
  endfunction
endpackage

// File: rtl/yuv_byte_packer.sv
// Assembles accepted bytes MSB-first into 32-bit words; word_valid marks the 4th byte (combinational).
module yuv_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_vld,
  input  logic [7:0]  in_dat,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  lane;
  logic [23:0] acc;

  // The 4th byte completes the word directly from the input, so no extra cycle is spent.
  assign word_valid = in_vld && (lane == 2'd3);
  assign word       = {acc, in_dat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= 2'd0;
      acc  <= 24'd0;
    end else if (clr) begin
      lane <= 2'd0;
      acc  <= 24'd0;
    end else if (in_vld) begin
      lane <= lane + 2'd1;
      acc  <= {acc[15:0], in_dat};
    end
  end
endmodule

// File: rtl/yuv_frame_packer.sv
// Packs one planar YUV420 byte frame into 32-bit BRAM words, Y then U then V, one word per address.
// Optional YUV_PACK_CHECKSUM_EN adds a wrapping 32-bit sum of all written words on port checksum.
module yuv_frame_packer
  import yuv_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [1:0]        plane,
  output logic              busy,
  output logic              frame_done
`ifdef YUV_PACK_CHECKSUM_EN
  , output logic [31:0]     checksum
`endif
);
  localparam int Y_WORDS     = WIDTH * HEIGHT / 4;
  localparam int C_WORDS     = WIDTH * HEIGHT / 16;
  localparam int FRAME_WORDS = Y_WORDS + 2 * C_WORDS;

  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(Y_WORDS - 1);
  localparam logic [ADDR_W-1:0] U_LAST = ADDR_W'(Y_WORDS + C_WORDS - 1);
  localparam logic [ADDR_W-1:0] V_LAST = ADDR_W'(FRAME_WORDS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] word_cnt;
  logic [31:0]       word;
  logic              word_valid;
  logic              accept;
  logic              arm;

  // pix_ready is a register, so accept never loops back through pix_valid.
  assign accept = pix_valid && pix_ready;
  assign arm    = (state == ST_IDLE) && start;

  yuv_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (arm),
    .in_vld     (accept),
    .in_dat     (pix_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_PLANE_Y;
      ST_PLANE_Y: if (word_valid && word_cnt == Y_LAST) state_nxt = ST_PLANE_U;
      ST_PLANE_U: if (word_valid && word_cnt == U_LAST) state_nxt = ST_PLANE_V;
      ST_PLANE_V: if (word_valid && word_cnt == V_LAST) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      plane      <= PLANE_NONE;
      busy       <= 1'b0;
      pix_ready  <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 32'd0;
      frame_done <= 1'b0;
      word_cnt   <= '0;
`ifdef YUV_PACK_CHECKSUM_EN
      checksum   <= 32'd0;
`endif
    end else begin
      state      <= state_nxt;
      plane      <= plane_of(state_nxt);
      busy       <= in_plane(state_nxt);
      pix_ready  <= in_plane(state_nxt);
      wr_en      <= word_valid;
      frame_done <= word_valid && (state == ST_PLANE_V) && (word_cnt == V_LAST);
      if (arm) begin
        word_cnt <= '0;
`ifdef YUV_PACK_CHECKSUM_EN
        checksum <= 32'd0;
`endif
      end else if (word_valid) begin
        wr_addr  <= word_cnt;
        wr_data  <= word;
        word_cnt <= word_cnt + 1'b1;
`ifdef YUV_PACK_CHECKSUM_EN
        checksum <= checksum + word;
`endif
      end
    end
  end
endmodule

// File: tb/tb_yuv_frame_packer.sv
// Directed bench for yuv_frame_packer on an 8x4 frame with a write scoreboard.
module tb_yuv_frame_packer;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int AW = 25;
  localparam int FW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = 8'h00;
  logic          pix_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [1:0]    plane;
  logic          busy;
  logic          frame_done;
`ifdef YUV_PACK_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  yuv_frame_packer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .plane      (plane),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef YUV_PACK_CHECKSUM_EN
    , .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          done;
    logic [1:0]    pl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   n_wr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Plane seen during the write of address a: the state has already advanced past a.
  function automatic logic [1:0] exp_plane(input int a);
    if (a + 1 < 8)       exp_plane = 2'd0;
    else if (a + 1 < 10) exp_plane = 2'd1;
    else if (a + 1 < 12) exp_plane = 2'd2;
    else                 exp_plane = 2'd3;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && wr_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected_write", {7'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", {7'd0, wr_addr}, {7'd0, e.addr});
        check("wr_data", wr_data, e.data);
        check("frame_done_with_write", {31'd0, frame_done}, {31'd0, e.done});
        check("plane_at_write", {30'd0, plane}, {30'd0, e.pl});
      end
    end else if (rst_n && frame_done) begin
      check("stray_frame_done", {31'd0, frame_done}, 32'd0);
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps && $urandom_range(0, 1) == 1) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    pix_valid = 1'b1;
    pix_data  = b;
    guard = 0;
    while (!pix_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!pix_ready) check("pix_ready_timeout", {31'd0, pix_ready}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] base, input int nbytes, input bit gaps);
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      if (i % 4 == 3) begin
        e.addr = AW'(i / 4);
        e.data = {8'(base + i - 3), 8'(base + i - 2), 8'(base + i - 1), 8'(base + i)};
        e.done = (i / 4 == FW - 1);
        e.pl   = exp_plane(i / 4);
        sb.push_back(e);
      end
      send_byte(8'(base + i), gaps);
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset with pix_valid held high
    rst_n = 1'b0;
    pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {7'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_plane", {30'd0, plane}, 32'd3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
`ifdef YUV_PACK_CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    pix_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_pix_ready", {31'd0, pix_ready}, 32'd0);

    // Single word latency
    do_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_plane", {30'd0, plane}, 32'd0);
    check("start_pix_ready", {31'd0, pix_ready}, 32'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check("no_early_write", {31'd0, wr_en}, 32'd0);
    e.addr = '0; e.data = 32'h1122_3344; e.done = 1'b0; e.pl = 2'd0;
    sb.push_back(e);
    send_byte(8'h44, 1'b0);
    pix_valid = 1'b0;
    check("lat_wr_en", {31'd0, wr_en}, 32'd1);
    check("lat_wr_addr", {7'd0, wr_addr}, 32'd0);
    check("lat_wr_data", wr_data, 32'h1122_3344);
    @(posedge clk); #1;
    check("lat_wr_en_one_cycle", {31'd0, wr_en}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_plane", {30'd0, plane}, 32'd3);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full frame back-to-back
    do_start();
    send_frame(8'h00, 48, 1'b0);
    check("done_pulse", {31'd0, frame_done}, 32'd1);
    check("done_plane", {30'd0, plane}, 32'd3);
    check("done_pix_ready", {31'd0, pix_ready}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
`ifdef YUV_PACK_CHECKSUM_EN
    check("checksum_final", checksum, 32'h0915_212C);
`endif
    @(posedge clk); #1;
    check("idle_frame_done", {31'd0, frame_done}, 32'd0);
    check("idle_wr_en", {31'd0, wr_en}, 32'd0);
    check("idle_plane", {30'd0, plane}, 32'd3);
    check("idle_pix_ready", {31'd0, pix_ready}, 32'd0);
`ifdef YUV_PACK_CHECKSUM_EN
    check("checksum_held", checksum, 32'h0915_212C);
`endif

    // Same frame with random valid gaps, started at the earliest legal cycle
    do_start();
    send_frame(8'h00, 48, 1'b1);
    check("gap_done_pulse", {31'd0, frame_done}, 32'd1);
`ifdef YUV_PACK_CHECKSUM_EN
    check("gap_checksum", checksum, 32'h0915_212C);
`endif
    @(posedge clk); #1;

    // Reset after 6 bytes discards the partial word
    do_start();
    send_frame(8'hA0, 6, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_discard_wr_en", {31'd0, wr_en}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("sb_empty_after_rst", sb.size(), 32'd0);
    do_start();
    send_frame(8'h00, 48, 1'b0);
    check("restart_done_pulse", {31'd0, frame_done}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    check("write_count", n_wr, 32'd38);
`ifdef YUV_PACK_CHECKSUM_EN
    check("checksum_hold_end", checksum, 32'h0915_212C);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
